// File: rtl/multiword_add_seq.sv
// multiword_add_seq: serial W-bit adder, one 16-bit CLA slice per cycle, valid/ready in and out.
// Define MWADD_OVF_EN to register a signed overflow flag on OVF (otherwise OVF is tied to 0).
module cla_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic [15:0] g, p, c;
   logic [3:0]  gg, gp;
   logic [4:0]  gc;
   always_comb begin
      g = a & b;
      p = a ^ b;
      gc = '0;
      gc[0] = ci;
      gg = '0;
      gp = '0;
      c = '0;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      // group carries come from lookahead; bits inside a group ripple locally
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j]   | (p[4*j]   & c[4*j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & c[4*j+1]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & c[4*j+2]);
      end
      s = p ^ c;
      co = gc[4];
   end
endmodule

module multiword_add_seq #(
   parameter int NSLICE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [16*NSLICE-1:0] A,
   input  logic [16*NSLICE-1:0] B,
   input  logic                 CI,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [16*NSLICE-1:0] S,
   output logic                 CO,
   output logic                 OVF
);
   localparam int W  = 16 * NSLICE;
   localparam int KW = $clog2(NSLICE);
   localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_r, b_r;
   logic [KW-1:0] k;
   logic          carry;
   logic [15:0]   a_sl, b_sl, sum;
   logic          co_sl;

   assign a_sl = a_r[16*k +: 16];
   assign b_sl = b_r[16*k +: 16];

   cla_16b u_cla (.a(a_sl), .b(b_sl), .ci(carry), .s(sum), .co(co_sl));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         k         <= '0;
         carry     <= 1'b0;
         S         <= '0;
         CO        <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= A;
                  b_r      <= B;
                  carry    <= CI;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               S[16*k +: 16] <= sum;
               carry         <= co_sl;
               k             <= k + 1'b1;
               if (k == KLAST) begin
                  CO        <= co_sl;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MWADD_OVF_EN
   // the top slice's sum is not yet in S on the finishing edge, so use the adder output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         OVF <= 1'b0;
      else if (state == CALC && k == KLAST)
         OVF <= (a_r[W-1] == b_r[W-1]) && (sum[15] != a_r[W-1]);
   end
`else
   assign OVF = 1'b0;
`endif

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NSLICE, default 4: number of 16-bit slices; operand width W = 16*NSLICE; legal range 2..8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 SHALL have ports A and B, input, W bits each: operands, two's complement.
REQ-007 SHALL have port CI, input, 1 bit: carry-in to slice 0.
REQ-008 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port S, output, W bits: sum.
REQ-011 SHALL have port CO, output, 1 bit: carry-out of the top slice.
REQ-012 SHALL have port OVF, output, 1 bit: signed overflow flag (see REQ-027).

Function
REQ-013 SHALL add one 16-bit slice per cycle through one internal cla_16b instance, chaining the carry through a carry register.
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
REQ-016 IDLE: on in_valid && in_ready, SHALL latch A, B and CI, clear slice index k to 0, load carry with CI, and go to CALC.
REQ-017 CALC, every cycle: SHALL add slice k of A and B plus carry, write the result to S[16k+15:16k], load carry from the slice CO, and increment k.
REQ-018 CALC with k = NSLICE-1: SHALL register the final carry to CO and go to DONE.
REQ-019 Latency: an accept at edge t SHALL give out_valid = 1 after edge t+NSLICE.
REQ-020 DONE: SHALL hold out_valid = 1; S, CO and OVF SHALL stay stable until out_valid && out_ready.
REQ-021 On the out_valid && out_ready edge, SHALL go to IDLE and deassert out_valid.
REQ-022 The earliest next accept SHALL be the edge after the return to IDLE; no overlap between transactions.
REQ-023 in_valid while not in IDLE SHALL be ignored; operand changes on A, B or CI during CALC SHALL have no effect.
REQ-024 S SHALL be the result modulo 2^W, with unsigned wrap reported through CO = 1.
REQ-025 In IDLE and CALC, S, CO and OVF SHALL hold their last values; their values are defined only while out_valid = 1.

Reset
REQ-026 With rst_n = 0, SHALL immediately force state IDLE, k=0, carry=0, S=0, CO=0, OVF=0, out_valid=0 and in_ready=0; SHALL drive in_ready=1 from the first edge after release; assertion mid-CALC or mid-DONE SHALL abort the transaction with no output.

Configuration
REQ-027 With macro MWADD_OVF_EN defined, SHALL register OVF on the DONE transition as (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]).
REQ-028 With MWADD_OVF_EN undefined, OVF SHALL be constant 0 and no overflow logic SHALL be present.

Verification (NSLICE=4)
REQ-029 A=0, B=0, CI=0 -> out_valid exactly 4 cycles after accept; S=0, CO=0, OVF=0.
REQ-030 A=64'hFFFF_FFFF_FFFF_FFFF, B=0, CI=1 -> S=0, CO=1 (carry through all 4 slices), OVF=0.
REQ-031 A=64'h7FFF_FFFF_FFFF_FFFF, B=1, CI=0 -> S=64'h8000_0000_0000_0000, CO=0, OVF=1 when MWADD_OVF_EN is defined and 0 when it is undefined.
REQ-032 A=444, B=666, CI=1 with out_ready held 0 for 3 cycles -> S=1111 held stable, in_ready=0 throughout, a second in_valid ignored, then handshake -> IDLE.
REQ-033 rst_n pulsed low during the 2nd CALC cycle -> out_valid never asserts and outputs are 0; a new transaction with A=32767, B=32767, CI=1 -> S=65535, CO=0.
REQ-034 Random A, B, CI (1000 transactions, random out_ready stalls) -> {CO,S} == A+B+CI and OVF matches the reference model.
